// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with START/STOP detection, LSB-first 8-bit address match and byte RX/TX.
// Optional: define I2C_SLAVE_GENERAL_CALL_EN to also ACK address 8'h00 (receive only).
module i2c_slave #(
    parameter logic [7:0]  SLAVE_ADDRESS = 8'hA5,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rw,
    input  logic [7:0] data_in,
    input  logic       sclk,
    input  logic       sda_in,
    output logic       sda_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       addr_match,
    output logic [2:0] state
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_ACK    = 3'd2,
        S_RX     = 3'd3,
        S_TX     = 3'd4,
        S_MACK   = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_sda_sync;
    logic                   r_sclk_d, r_sda_d;
    logic                   w_sclk, w_sda, w_sclk_rise, w_sclk_fall, w_start, w_stop;

    state_t     r_state, w_state_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    logic [7:0] r_shift, w_shift_nxt, r_tx, w_tx_nxt, r_data_out, w_data_out_nxt;
    logic       r_sda_out, w_sda_out_nxt, r_data_valid, w_data_valid_nxt;
    logic       r_addr_match, w_addr_match_nxt, r_rw, w_rw_nxt;
    // ACK: 1 once SDA is held low; TX: 1 once all 8 bits have been driven
    logic       r_phase, w_phase_nxt;
    logic [7:0] w_byte;
    logic       w_addr_hit, w_tx_ok;

    // Input synchronisers and one-flop edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '1;
            r_sda_sync  <= '1;
            r_sclk_d    <= 1'b1;
            r_sda_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_sda_sync  <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_sclk_d    <= w_sclk;
            r_sda_d     <= w_sda;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_sda       = r_sda_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_start     = w_sclk & r_sclk_d & r_sda_d & ~w_sda;
    assign w_stop      = w_sclk & r_sclk_d & ~r_sda_d & w_sda;
    assign w_byte      = {w_sda, r_shift[7:1]};

`ifdef I2C_SLAVE_GENERAL_CALL_EN
    logic r_gc, w_gc_nxt;
    assign w_addr_hit = (w_byte == SLAVE_ADDRESS) || (w_byte == 8'h00);
    assign w_tx_ok    = r_rw & ~r_gc;
`else
    assign w_addr_hit = (w_byte == SLAVE_ADDRESS);
    assign w_tx_ok    = r_rw;
`endif

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 3'd0;
            r_shift      <= 8'h00;
            r_tx         <= 8'h00;
            r_sda_out    <= 1'b1;
            r_data_out   <= 8'h00;
            r_data_valid <= 1'b0;
            r_addr_match <= 1'b0;
            r_rw         <= 1'b0;
            r_phase      <= 1'b0;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
            r_gc         <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_tx         <= w_tx_nxt;
            r_sda_out    <= w_sda_out_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_addr_match <= w_addr_match_nxt;
            r_rw         <= w_rw_nxt;
            r_phase      <= w_phase_nxt;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
            r_gc         <= w_gc_nxt;
`endif
        end
    end

    // Next-state and output logic; STOP beats START beats everything else
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_shift_nxt      = r_shift;
        w_tx_nxt         = r_tx;
        w_sda_out_nxt    = r_sda_out;
        w_data_out_nxt   = r_data_out;
        w_data_valid_nxt = 1'b0;
        w_addr_match_nxt = r_addr_match;
        w_rw_nxt         = r_rw;
        w_phase_nxt      = r_phase;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        w_gc_nxt         = r_gc;
`endif
        if (w_stop) begin
            w_state_nxt      = S_IDLE;
            w_sda_out_nxt    = 1'b1;
            w_addr_match_nxt = 1'b0;
            w_cnt_nxt        = 3'd0;
            w_phase_nxt      = 1'b0;
        end else if (w_start) begin
            w_state_nxt      = S_ADDR;
            w_sda_out_nxt    = 1'b1;
            w_addr_match_nxt = 1'b0;
            w_cnt_nxt        = 3'd0;
            w_phase_nxt      = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: w_sda_out_nxt = 1'b1;
                S_ADDR: begin
                    if (w_sclk_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            if (w_addr_hit) begin
                                w_state_nxt      = S_ACK;
                                w_addr_match_nxt = 1'b1;
                                w_rw_nxt         = rw;
                                w_phase_nxt      = 1'b0;
`ifdef I2C_SLAVE_GENERAL_CALL_EN
                                w_gc_nxt         = (w_byte == 8'h00);
`endif
                            end else begin
                                w_state_nxt = S_IGNORE;
                            end
                        end
                    end
                end
                S_ACK: begin
                    if (w_sclk_fall) begin
                        if (!r_phase) begin
                            w_sda_out_nxt = 1'b0;
                            w_phase_nxt   = 1'b1;
                        end else begin
                            w_phase_nxt = 1'b0;
                            w_cnt_nxt   = 3'd0;
                            if (w_tx_ok) begin
                                // Bit 0 goes out on the same falling edge that releases the ACK
                                w_state_nxt   = S_TX;
                                w_tx_nxt      = data_in;
                                w_sda_out_nxt = data_in[0];
                                w_cnt_nxt     = 3'd1;
                            end else if (r_rw) begin
                                w_state_nxt   = S_IGNORE;
                                w_sda_out_nxt = 1'b1;
                            end else begin
                                w_state_nxt   = S_RX;
                                w_sda_out_nxt = 1'b1;
                            end
                        end
                    end
                end
                S_RX: begin
                    if (w_sclk_rise) begin
                        w_shift_nxt = w_byte;
                        w_cnt_nxt   = r_cnt + 3'd1;
                        if (r_cnt == 3'd7) begin
                            w_data_out_nxt   = w_byte;
                            w_data_valid_nxt = 1'b1;
                            w_state_nxt      = S_ACK;
                            w_phase_nxt      = 1'b0;
                        end
                    end
                end
                S_TX: begin
                    if (w_sclk_fall) begin
                        if (r_phase) begin
                            w_sda_out_nxt = 1'b1;
                            w_state_nxt   = S_MACK;
                            w_phase_nxt   = 1'b0;
                        end else begin
                            w_sda_out_nxt = r_tx[r_cnt];
                            w_cnt_nxt     = r_cnt + 3'd1;
                            w_phase_nxt   = (r_cnt == 3'd7);
                        end
                    end
                end
                S_MACK: begin
                    if (w_sclk_rise) begin
                        if (!w_sda) begin
                            w_state_nxt = S_TX;
                            w_tx_nxt    = data_in;
                            w_cnt_nxt   = 3'd0;
                            w_phase_nxt = 1'b0;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_IGNORE: w_sda_out_nxt = 1'b1;
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_sda_out_nxt = 1'b1;
                end
            endcase
        end
    end

    assign sda_out    = r_sda_out;
    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign addr_match = r_addr_match;
    assign state      = r_state;
endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: bit-banged I2C master on a wired-AND bus, table of write transactions plus
// hand sequences for read, repeated START and mid-ACK reset.
module tb_i2c_slave;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst, rw, sclk, m_sda;
    logic [7:0] data_in;
    logic       sda_in, sda_out, data_valid, addr_match;
    logic [7:0] data_out;
    logic [2:0] state;

    assign sda_in = m_sda & sda_out;
    always #5 clk = ~clk;

    i2c_slave dut (
        .clk        (clk),
        .rst        (rst),
        .rw         (rw),
        .data_in    (data_in),
        .sclk       (sclk),
        .sda_in     (sda_in),
        .sda_out    (sda_out),
        .data_out   (data_out),
        .data_valid (data_valid),
        .addr_match (addr_match),
        .state      (state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int low_cnt = 0;

    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (!sda_out) low_cnt++;
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       addr_ack;
        logic [7:0] exp_dout;
        int         exp_dv;
        logic [2:0] exp_state;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q(input int n);
        repeat (n * Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q(1);
        sclk  = 1'b1; wait_q(1);
        m_sda = 1'b0; wait_q(1);
        sclk  = 1'b0; wait_q(1);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q(1);
        sclk  = 1'b1; wait_q(1);
        m_sda = 1'b1; wait_q(2);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        m_sda = b;    wait_q(1);
        sclk  = 1'b1; wait_q(1);
        r = sda_in;   wait_q(1);
        sclk  = 1'b0; wait_q(1);
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        logic d;
        for (int i = 0; i < 8; i++) clock_bit(v[i], d);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] v);
        logic b;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, b);
            v[i] = b;
        end
    endtask

    initial begin
        logic       ack, d;
        logic [7:0] rb;
        int         dvb, lowb;

        vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'h3C, 1, 3'd3};
        vecs[1] = '{8'h5A, 8'h99, 1'b1, 8'h3C, 0, 3'd6};
        vecs[2] = '{8'hA5, 8'hFF, 1'b0, 8'hFF, 1, 3'd3};
        vecs[3] = '{8'hA4, 8'h12, 1'b1, 8'hFF, 0, 3'd6};
        vecs[4] = '{8'h25, 8'h34, 1'b1, 8'hFF, 0, 3'd6};
        vecs[5] = '{8'hA5, 8'h01, 1'b0, 8'h01, 1, 3'd3};
`ifdef I2C_SLAVE_GENERAL_CALL_EN
        vecs[6] = '{8'h00, 8'h7E, 1'b0, 8'h7E, 1, 3'd3};
`else
        vecs[6] = '{8'h00, 8'h7E, 1'b1, 8'h01, 0, 3'd6};
`endif

        rst = 1'b1; rw = 1'b0; sclk = 1'b1; m_sda = 1'b1; data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset sda_out", 32'(sda_out), 32'd1);
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset data_valid", 32'(data_valid), 32'd0);
        chk("reset addr_match", 32'(addr_match), 32'd0);
        chk("reset state", 32'(state), 32'd0);

        // Table-driven write transactions
        for (int k = 0; k < 7; k++) begin
            dvb = dv_cnt; lowb = low_cnt;
            i2c_start();
            send_byte(vecs[k].addr, ack);
            chk($sformatf("vec%0d addr ack", k), 32'(ack), 32'(vecs[k].addr_ack));
            chk($sformatf("vec%0d addr_match", k), 32'(addr_match), 32'(!vecs[k].addr_ack));
            send_byte(vecs[k].wdata, ack);
            chk($sformatf("vec%0d data ack", k), 32'(ack), 32'(vecs[k].addr_ack));
            chk($sformatf("vec%0d state", k), 32'(state), 32'(vecs[k].exp_state));
            chk($sformatf("vec%0d data_out", k), 32'(data_out), 32'(vecs[k].exp_dout));
            chk($sformatf("vec%0d dv pulses", k), 32'(dv_cnt - dvb), 32'(vecs[k].exp_dv));
            if (vecs[k].addr_ack) chk($sformatf("vec%0d sda low cycles", k), 32'(low_cnt - lowb), 32'd0);
            i2c_stop();
            chk($sformatf("vec%0d state after stop", k), 32'(state), 32'd0);
            chk($sformatf("vec%0d addr_match after stop", k), 32'(addr_match), 32'd0);
        end

        // Read: master ACKs byte 1, NACKs byte 2
        rw = 1'b1; data_in = 8'hC3;
        i2c_start();
        send_byte(8'hA5, ack);
        chk("read addr ack", 32'(ack), 32'd0);
        chk("read state TX", 32'(state), 32'd4);
        read_byte(1'b0, rb);
        chk("read byte1", 32'(rb), 32'hC3);
        data_in = 8'h81;
        clock_bit(1'b0, d);
        read_byte(1'b1, rb);
        chk("read byte2", 32'(rb), 32'h81);
        clock_bit(1'b1, d);
        chk("read nack sda_out", 32'(sda_out), 32'd1);
        chk("read nack state", 32'(state), 32'd6);
        chk("read nack addr_match", 32'(addr_match), 32'd1);
        i2c_stop();
        chk("read state after stop", 32'(state), 32'd0);
        rw = 1'b0;

        // Repeated START in the middle of an RX byte
        dvb = dv_cnt;
        i2c_start();
        send_byte(8'hA5, ack);
        chk("rs addr ack", 32'(ack), 32'd0);
        clock_bit(1'b0, d); clock_bit(1'b1, d); clock_bit(1'b0, d); clock_bit(1'b1, d);
        i2c_start();
        chk("rs state ADDR", 32'(state), 32'd1);
        chk("rs addr_match cleared", 32'(addr_match), 32'd0);
        chk("rs no dv", 32'(dv_cnt - dvb), 32'd0);
        send_byte(8'hA5, ack);
        chk("rs second addr ack", 32'(ack), 32'd0);
        send_byte(8'h55, ack);
        chk("rs data ack", 32'(ack), 32'd0);
        chk("rs data_out", 32'(data_out), 32'h55);
        chk("rs dv pulses", 32'(dv_cnt - dvb), 32'd1);
        i2c_stop();

        // Reset while the slave is holding ACK low
        i2c_start();
        for (int i = 0; i < 8; i++) clock_bit(1'(8'hA5 >> i), d);
        m_sda = 1'b1;
        chk("ack held low", 32'(sda_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst sda_out async", 32'(sda_out), 32'd1);
        chk("rst data_out", 32'(data_out), 32'h00);
        chk("rst data_valid", 32'(data_valid), 32'd0);
        chk("rst addr_match", 32'(addr_match), 32'd0);
        chk("rst state", 32'(state), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lowb = low_cnt;
        clock_bit(1'b0, d); clock_bit(1'b1, d); clock_bit(1'b0, d);
        chk("post-rst idle state", 32'(state), 32'd0);
        chk("post-rst sda released", 32'(low_cnt - lowb), 32'd0);
        i2c_stop();
        chk("post-rst state after stop", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
